// File: rtl/l2_loss_stream.sv
`default_nettype none
// ============================================================================
// Module   : l2_loss_stream
// Function : Streaming sum-of-squared-error engine over masked lane beats, with
//            sticky saturation and an optional sequential mean divider.
// Revision : 1.0
// ============================================================================
module l2_loss_stream #(
    parameter int IL    = 4,
    parameter int FL    = 16,
    parameter int LANES = 16,
    parameter int CNT_W = 16
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic                                       in_valid,
    output logic                                       in_ready,
    input  logic                                       in_last,
    input  logic                                       mode,
    input  logic [$clog2(LANES+1)-1:0]                 num,
    input  logic [LANES-1:0][IL+FL-1:0]                yHat,
    input  logic [LANES-1:0][IL+FL-1:0]                y,
    output logic                                       out_valid,
    input  logic                                       out_ready,
    output logic signed [IL+FL-1:0]                    out_sum,
    output logic [CNT_W-1:0]                           out_count,
    output logic                                       out_sat
);

    localparam int W      = IL + FL;
    localparam int NUM_W  = $clog2(LANES + 1);
    localparam int D_W    = W + 1;
    localparam int P_W    = 2 * D_W;
    localparam int SQ_W   = P_W - FL;
    localparam int LVL    = $clog2(LANES);
    localparam int PAD    = 1 << LVL;
    localparam int SUM_W  = SQ_W + LVL;
    localparam int ACC_W  = SUM_W + 1;
    localparam int CNT_X  = CNT_W + 1;
    localparam int DIVC_W = $clog2(W);
    localparam logic [W-1:0] ACC_MAX = {1'b0, {(W-1){1'b1}}};

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACCUM  = 3'd1,
        DRAIN0 = 3'd2,
        DRAIN1 = 3'd3,
        DIV    = 3'd4,
        DONE   = 3'd5
    } state_t;

    function automatic logic [SQ_W-1:0] lane_sq(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [D_W-1:0] d;
        logic signed [P_W-1:0] p;
        d = $signed({a[W-1], a}) - $signed({b[W-1], b});
        p = d * d;
        return SQ_W'(p >>> FL);
    endfunction

    function automatic logic [SUM_W-1:0] tree_sum(input logic [SQ_W-1:0] v [LANES]);
        logic [SUM_W-1:0] node [2*PAD-1];
        for (int i = 0; i < 2*PAD-1; i++) node[i] = '0;
        for (int k = 0; k < LANES; k++) node[PAD-1+k] = SUM_W'(v[k]);
        // Heap layout: node i sums children 2i+1 and 2i+2; root lands in node 0.
        for (int i = PAD-2; i >= 0; i--) node[i] = node[2*i+1] + node[2*i+2];
        return node[0];
    endfunction

    state_t              state_q, state_d;
    logic [SQ_W-1:0]     s1_sq_q [LANES];
    logic [SQ_W-1:0]     s1_sq_d [LANES];
    logic [NUM_W-1:0]    s1_num_q, s1_num_d;
    logic [SUM_W-1:0]    s2_sum_q, s2_sum_d;
    logic [NUM_W-1:0]    s2_num_q, s2_num_d;
    logic [W-1:0]        acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                sat_q, sat_d;
    logic                mean_q, mean_d;
    logic [W-1:0]        quo_q, quo_d;
    logic [CNT_W-1:0]    rem_q, rem_d;
    logic [DIVC_W-1:0]   dcnt_q, dcnt_d;

    logic                accept;
    logic                done;
    logic [NUM_W-1:0]    num_c;
    logic [ACC_W-1:0]    acc_sum;
    logic [CNT_X-1:0]    cnt_sum;
    logic [CNT_X-1:0]    rem_sh;

    assign in_ready = !reset && (state_q == IDLE || state_q == ACCUM);
    assign accept   = in_valid && in_ready;

    // S1: masked per-lane squares; idle cycles inject zeros so later stages need no valid.
    always_comb begin
        num_c    = (num > NUM_W'(LANES)) ? NUM_W'(LANES) : num;
        s1_num_d = accept ? num_c : '0;
        for (int k = 0; k < LANES; k++) begin
            s1_sq_d[k] = (accept && (NUM_W'(k) < num_c)) ? lane_sq(yHat[k], y[k]) : '0;
        end
    end

    always_comb begin
        s2_sum_d = tree_sum(s1_sq_q);
        s2_num_d = s1_num_q;
    end

    always_comb begin
        acc_sum = ACC_W'(acc_q) + ACC_W'(s2_sum_q);
        cnt_sum = CNT_X'(cnt_q) + CNT_X'(s2_num_q);
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        mean_d  = mean_q;
        if (state_q == IDLE && accept) begin
            acc_d  = '0;
            cnt_d  = '0;
            sat_d  = 1'b0;
            mean_d = mode;
        end else begin
            if (acc_sum > ACC_W'(ACC_MAX)) begin
                acc_d = ACC_MAX;
                sat_d = 1'b1;
            end else begin
                acc_d = acc_sum[W-1:0];
            end
            if (cnt_sum[CNT_W]) begin
                cnt_d = '1;
                sat_d = 1'b1;
            end else begin
                cnt_d = cnt_sum[CNT_W-1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dcnt_d  = dcnt_q;
        rem_sh  = {rem_q, quo_q[W-1]};
        case (state_q)
            IDLE:   if (accept) state_d = in_last ? DRAIN0 : ACCUM;
            ACCUM:  if (accept && in_last) state_d = DRAIN0;
            DRAIN0: state_d = DRAIN1;
            DRAIN1: begin
                // The last beat's S3 update lands on this edge, so decide on next-state values.
                if (mean_q && cnt_d != '0) begin
                    state_d = DIV;
                    quo_d   = acc_d;
                    rem_d   = '0;
                    dcnt_d  = '0;
                end else begin
                    state_d = DONE;
                end
            end
            DIV: begin
                if (rem_sh >= {1'b0, cnt_q}) begin
                    rem_d = CNT_W'(rem_sh - {1'b0, cnt_q});
                    quo_d = {quo_q[W-2:0], 1'b1};
                end else begin
                    rem_d = rem_sh[CNT_W-1:0];
                    quo_d = {quo_q[W-2:0], 1'b0};
                end
                dcnt_d = dcnt_q + 1'b1;
                if (dcnt_q == DIVC_W'(W-1)) state_d = DONE;
            end
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            for (int k = 0; k < LANES; k++) s1_sq_q[k] <= '0;
            s1_num_q <= '0;
            s2_sum_q <= '0;
            s2_num_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            sat_q    <= 1'b0;
            mean_q   <= 1'b0;
            quo_q    <= '0;
            rem_q    <= '0;
            dcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            for (int k = 0; k < LANES; k++) s1_sq_q[k] <= s1_sq_d[k];
            s1_num_q <= s1_num_d;
            s2_sum_q <= s2_sum_d;
            s2_num_q <= s2_num_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            sat_q    <= sat_d;
            mean_q   <= mean_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            dcnt_q   <= dcnt_d;
        end
    end

    assign done      = (state_q == DONE);
    assign out_valid = done;
    assign out_sum   = !done ? '0 : ((mean_q && cnt_q != '0) ? quo_q : acc_q);
    assign out_count = done ? cnt_q : '0;
    assign out_sat   = done && sat_q;

endmodule
`default_nettype wire

// File: tb/tb_l2_loss_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_l2_loss_stream
// Function : Directed self-checking bench for l2_loss_stream.
// Revision : 1.0
// ============================================================================
module tb_l2_loss_stream;

    localparam int IL    = 4;
    localparam int FL    = 16;
    localparam int LANES = 16;
    localparam int CNT_W = 16;
    localparam int W     = IL + FL;
    localparam int NW    = $clog2(LANES + 1);

    logic                         clk = 1'b0;
    logic                         reset;
    logic                         in_valid;
    logic                         in_ready;
    logic                         in_last;
    logic                         mode;
    logic [NW-1:0]                num;
    logic [LANES-1:0][W-1:0]      yhat_r;
    logic [LANES-1:0][W-1:0]      y_r;
    logic                         out_valid;
    logic                         out_ready;
    logic [W-1:0]                 out_sum;
    logic [CNT_W-1:0]             out_count;
    logic                         out_sat;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    l2_loss_stream #(.IL(IL), .FL(FL), .LANES(LANES), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .mode      (mode),
        .num       (num),
        .yHat      (yhat_r),
        .y         (y_r),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count),
        .out_sat   (out_sat)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Active lanes get (yh, yy); masked lanes carry a large diff that must never count.
    task automatic fill(input int n, input logic [W-1:0] yh, input logic [W-1:0] yy);
        for (int k = 0; k < LANES; k++) begin
            if (k < n) begin
                yhat_r[k] = yh;
                y_r[k]    = yy;
            end else begin
                yhat_r[k] = 20'd196608;
                y_r[k]    = 20'(-196608);
            end
        end
    endtask

    // Called at a negedge; returns at the first negedge after the accepting posedge.
    task automatic send(input logic [NW-1:0] n, input logic m, input logic last);
        int t;
        num      = n;
        mode     = m;
        in_last  = last;
        in_valid = 1'b1;
        t        = 0;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) chk("accept_timeout", in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_out(input string tag, input int exp_lat);
        int lat;
        lat = 1;
        while (!out_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"}, lat, exp_lat);
    endtask

    task automatic check_res(input string tag, input int s, input int c, input logic st);
        chk({tag, "_sum"}, out_sum, s);
        chk({tag, "_count"}, out_count, c);
        chk({tag, "_sat"}, out_sat, st);
    endtask

    task automatic take();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("post_take_valid", out_valid, 0);
        chk("post_take_ready", in_ready, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_sum"}, out_sum, 0);
        chk({tag, "_count"}, out_count, 0);
        chk({tag, "_sat"}, out_sat, 0);
        chk({tag, "_ready"}, in_ready, 0);
    endtask

    task automatic load_basic();
        fill(2, '0, '0);
        yhat_r[0] = 20'd65536;
        yhat_r[1] = 20'd131072;
        y_r[1]    = 20'd32768;
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        mode      = 1'b0;
        num       = '0;
        out_ready = 1'b0;
        fill(0, '0, '0);
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;
        @(negedge clk);
        chk("idle_ready", in_ready, 1);

        // Sum: 1.0^2 + 1.5^2 = 3.25
        load_basic();
        send(5'd2, 1'b0, 1'b1);
        wait_out("sum1", 3);
        check_res("sum1", 212992, 2, 1'b0);
        take();

        // Mean of the same: 1.625
        load_basic();
        send(5'd2, 1'b1, 1'b1);
        wait_out("mean1", 23);
        check_res("mean1", 106496, 2, 1'b0);
        take();

        // 3.0^2 = 9.0 clamps to the format maximum; then hold the result under backpressure
        fill(1, 20'd196608, '0);
        send(5'd1, 1'b0, 1'b1);
        wait_out("sat", 3);
        check_res("sat", 524287, 1, 1'b1);
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_valid", out_valid, 1);
            chk("bp_sum", out_sum, 524287);
            chk("bp_count", out_count, 1);
            chk("bp_sat", out_sat, 1);
            chk("bp_ready", in_ready, 0);
        end
        take();

        // Three beats with gaps, diff 0.25 each: 20 * 0.0625 = 1.25; later beats' mode ignored
        fill(16, 20'(-8192), 20'(-24576));
        send(5'd16, 1'b0, 1'b0);
        @(negedge clk);
        fill(4, 20'(-8192), 20'(-24576));
        send(5'd4, 1'b1, 1'b0);
        @(negedge clk);
        fill(0, '0, '0);
        send(5'd0, 1'b1, 1'b1);
        wait_out("multi", 3);
        check_res("multi", 81920, 20, 1'b0);
        take();

        fill(16, 20'(-8192), 20'(-24576));
        send(5'd16, 1'b1, 1'b0);
        @(negedge clk);
        fill(4, 20'(-8192), 20'(-24576));
        send(5'd4, 1'b0, 1'b0);
        @(negedge clk);
        fill(0, '0, '0);
        send(5'd0, 1'b0, 1'b1);
        wait_out("multimean", 23);
        check_res("multimean", 4096, 20, 1'b0);
        take();

        // Negative diff -0.75 -> 0.5625; a diff of 3 LSB floors to zero
        fill(2, '0, '0);
        yhat_r[0] = 20'(-32768);
        y_r[0]    = 20'd16384;
        yhat_r[1] = 20'd3;
        send(5'd2, 1'b0, 1'b1);
        wait_out("neg", 3);
        check_res("neg", 36864, 2, 1'b0);
        take();

        // num above LANES is clamped to all 16 lanes
        fill(16, 20'(-8192), 20'(-24576));
        send(5'd31, 1'b0, 1'b1);
        wait_out("clamp", 3);
        check_res("clamp", 65536, 16, 1'b0);
        take();

        // Mean floors: 2.0 / 3
        fill(3, '0, '0);
        yhat_r[0] = 20'd65536;
        yhat_r[1] = 20'd65536;
        send(5'd3, 1'b1, 1'b1);
        wait_out("floor", 23);
        check_res("floor", 43690, 3, 1'b0);
        take();

        // Mean with zero elements skips the divider
        fill(0, '0, '0);
        send(5'd0, 1'b1, 1'b1);
        wait_out("zero", 3);
        check_res("zero", 0, 0, 1'b0);
        take();

        // Mean of a clamped accumulator
        fill(2, 20'd196608, '0);
        send(5'd2, 1'b1, 1'b1);
        wait_out("satmean", 23);
        check_res("satmean", 262143, 2, 1'b1);
        take();

        // Reset in the middle of a saturating packet, then a fresh packet
        fill(16, 20'd196608, '0);
        send(5'd16, 1'b0, 1'b0);
        send(5'd16, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        check_reset_outputs("midreset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        load_basic();
        send(5'd2, 1'b0, 1'b1);
        wait_out("fresh", 3);
        check_res("fresh", 212992, 2, 1'b0);
        take();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
